// File: rtl/playback_pkg.sv
// Shared playback state encodings and defaults for the tick controller slice.
// Pure declarations: no latency, no flow control.
package playback_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_FFWD    = 2'd3
  } play_state_e;

  localparam int ADDER_W_DEF = 6;

  function automatic logic is_running(input play_state_e s);
    return (s == ST_PLAYING) || (s == ST_FFWD);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by CLK_FREQ_HZ while running; wrap is a registered one-cycle pulse.
// Latency: wrap rises on the edge where the count leaves CLK_FREQ_HZ-1; no backpressure, hold freezes phase.
module tick_prescaler #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic hold,
  input  logic clear,
  output logic wrap,
  output logic at_wrap
);

  localparam int CNT_W = $clog2(CLK_FREQ_HZ);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_FREQ_HZ - 1);

  logic [CNT_W-1:0] cnt;

  // Wrap is still reported when clear coincides with it, so a stop on the
  // wrap edge does not swallow that second's tick.
  assign at_wrap = run && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= at_wrap;
      if (clear || at_wrap)
        cnt <= '0;
      else if (run)
        cnt <= cnt + CNT_W'(1);
      else if (!hold)
        cnt <= '0;
    end
  end

endmodule

// File: rtl/playback_tick_ctrl.sv
// Transport-command FSM feeding the elapsed-time counter with tick, count, adder and timer_reset.
// Latency: all outputs registered, one edge after the command; commands are pulses, never back-pressured.
module playback_tick_ctrl
  import playback_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int FF_STEP     = 4,
  parameter int ADDER_W     = ADDER_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play_pause,
  input  logic               stop,
  input  logic               end_of_track,
  input  logic               ffwd,
  output logic               tick,
  output logic               count,
  output logic [ADDER_W-1:0] adder,
  output logic               timer_reset,
  output logic [1:0]         state
);

  play_state_e state_q;
  play_state_e state_d;
  play_state_e view_s;
  logic        kill;
  logic        at_wrap;
  logic        init_pending;

  always_comb begin
    kill    = stop || (end_of_track && (state_q != ST_STOPPED));
    state_d = state_q;
    case (state_q)
      ST_STOPPED: if (!stop && play_pause) state_d = ffwd ? ST_FFWD : ST_PLAYING;
      ST_PLAYING: begin
        if (kill)            state_d = ST_STOPPED;
        else if (play_pause) state_d = ST_PAUSED;
        else if (ffwd)       state_d = ST_FFWD;
      end
      ST_FFWD: begin
        if (kill)            state_d = ST_STOPPED;
        else if (play_pause) state_d = ST_PAUSED;
        else if (!ffwd)      state_d = ST_PLAYING;
      end
      ST_PAUSED: begin
        if (kill)            state_d = ST_STOPPED;
        else if (play_pause) state_d = ffwd ? ST_FFWD : ST_PLAYING;
      end
      default: state_d = ST_STOPPED;
    endcase
    // On a tick edge the counter must see the state that earned the tick.
    view_s = at_wrap ? state_q : state_d;
  end

  tick_prescaler #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .run    (is_running(state_q)),
    .hold   (state_q == ST_PAUSED),
    .clear  ((state_q == ST_STOPPED) || kill),
    .wrap   (tick),
    .at_wrap(at_wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_STOPPED;
      count        <= 1'b0;
      adder        <= '0;
      timer_reset  <= 1'b0;
      init_pending <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_reset  <= init_pending || kill;
      init_pending <= 1'b0;
      count        <= is_running(view_s);
      if (view_s == ST_FFWD)
        adder <= ADDER_W'(FF_STEP);
      else if (view_s == ST_PLAYING)
        adder <= ADDER_W'(1);
      else
        adder <= '0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_playback_tick_ctrl.sv
// Randomized and directed bench for playback_tick_ctrl against a behavioural model.
// Inputs change and outputs are sampled on the falling edge.
module tb_playback_tick_ctrl;

  localparam int CLK = 10;
  localparam int FFS = 4;
  localparam int AW  = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          play_pause = 1'b0;
  logic          stop = 1'b0;
  logic          end_of_track = 1'b0;
  logic          ffwd = 1'b0;
  logic          tick;
  logic          count;
  logic [AW-1:0] adder;
  logic          timer_reset;
  logic [1:0]    state;

  int n_vec = 0;
  int n_err = 0;

  // model: 0 stopped, 1 playing, 2 paused, 3 fast-forward
  int m_state, m_phase, m_adder;
  bit m_init, m_tick, m_count, m_tr;

  always #5 clk = ~clk;

  playback_tick_ctrl #(
    .CLK_FREQ_HZ(CLK),
    .FF_STEP    (FFS),
    .ADDER_W    (AW)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .play_pause  (play_pause),
    .stop        (stop),
    .end_of_track(end_of_track),
    .ffwd        (ffwd),
    .tick        (tick),
    .count       (count),
    .adder       (adder),
    .timer_reset (timer_reset),
    .state       (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int secs_per_tick(input int s);
    return (s == 1) ? 1 : (s == 3) ? FFS : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_phase = 0; m_init = 1'b1;
    m_tick = 1'b0; m_count = 1'b0; m_adder = 0; m_tr = 1'b0;
  endtask

  task automatic model_step(input bit pp, input bit st, input bit eot, input bit ff);
    bit moving, kill, wraps;
    int nxt, seen;
    moving = (m_state == 1) || (m_state == 3);
    kill   = st || (eot && m_state != 0);
    if (kill)        nxt = 0;
    else if (pp)     nxt = moving ? 2 : (ff ? 3 : 1);
    else if (moving) nxt = ff ? 3 : 1;
    else             nxt = m_state;
    wraps   = moving && (m_phase == CLK - 1);
    m_phase = (kill || m_state == 0) ? 0 : (moving ? (m_phase + 1) % CLK : m_phase);
    m_tick  = wraps;
    m_tr    = m_init || kill;
    m_init  = 1'b0;
    seen    = wraps ? m_state : nxt;
    m_count = (seen == 1) || (seen == 3);
    m_adder = secs_per_tick(seen);
    m_state = nxt;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_tick"},  tick,        m_tick);
    chk({tag, "_count"}, count,       m_count);
    chk({tag, "_adder"}, adder,       m_adder);
    chk({tag, "_tr"},    timer_reset, m_tr);
    chk({tag, "_state"}, state,       m_state);
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic cycle(input bit pp, input bit st, input bit eot);
    play_pause = pp; stop = st; end_of_track = eot;
    @(posedge clk);
    model_step(pp, st, eot, ffwd);
    @(negedge clk);
    check_all("cyc");
    play_pause = 1'b0; stop = 1'b0; end_of_track = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks, trs, first, r;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("rst");
    reset = 1'b1;

    // idle after reset: one startup clear, no ticks
    ticks = 0; trs = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(0, 0, 0);
      ticks += int'(tick); trs += int'(timer_reset);
    end
    chk("idle_ticks", ticks, 0);
    chk("startup_tr", trs, 1);

    // play: first tick CLK cycles after the command
    cycle(1, 0, 0);
    first = 0;
    for (int k = 1; k <= 25; k++) begin
      cycle(0, 0, 0);
      if (tick && first == 0) first = k;
    end
    chk("first_tick", first, CLK);

    // fast-forward and back
    ffwd = 1'b1;
    repeat (30) cycle(0, 0, 0);
    chk("ffwd_state", state, 3);
    ffwd = 1'b0;
    repeat (15) cycle(0, 0, 0);
    chk("play_state", state, 1);

    // pause keeps sub-second phase
    cycle(0, 1, 0);
    cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("paused_state", state, 2);
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(0, 0, 0);
      ticks += int'(tick);
    end
    chk("paused_ticks", ticks, 0);
    cycle(1, 0, 0);
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle(0, 0, 0);
      if (tick && first == 0) first = k;
    end
    chk("resume_tick", first, 6);

    // stop exactly on the wrap edge
    cycle(0, 1, 0);
    cycle(1, 0, 0);
    repeat (CLK - 1) cycle(0, 0, 0);
    cycle(0, 1, 0);
    chk("wrap_stop_tick", tick, 1);
    chk("wrap_stop_count", count, 1);
    chk("wrap_stop_adder", adder, 1);
    chk("wrap_stop_tr", timer_reset, 1);
    chk("wrap_stop_state", state, 0);
    cycle(1, 0, 0);
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle(0, 0, 0);
      if (tick && first == 0) first = k;
    end
    chk("post_stop_tick", first, CLK);

    // random command traffic
    for (int i = 0; i < 3000; i++) begin
      bit pp, st, eot;
      r   = int'($urandom_range(0, 99));
      pp  = (r < 6);
      st  = (r >= 6) && (r < 8);
      eot = (r >= 8) && (r < 10);
      if ($urandom_range(0, 49) == 0) begin pp = 1'b1; eot = 1'b1; end
      if ($urandom_range(0, 19) == 0) ffwd = ~ffwd;
      cycle(pp, st, eot);
    end

    // asynchronous reset while a fast-forward tick is high
    ffwd = 1'b1;
    cycle(0, 1, 0);
    cycle(1, 0, 0);
    repeat (CLK) cycle(0, 0, 0);
    chk("pre_rst_tick", tick, 1);
    chk("pre_rst_adder", adder, FFS);
    #2 reset = 1'b0;
    #1;
    chk("arst_tick", tick, 0);
    chk("arst_count", count, 0);
    chk("arst_adder", adder, 0);
    chk("arst_tr", timer_reset, 0);
    chk("arst_state", state, 0);
    model_reset();
    @(negedge clk);
    check_all("arst_hold");
    reset = 1'b1;
    ffwd = 1'b0;
    trs = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0);
      trs += int'(timer_reset);
    end
    chk("restart_tr", trs, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/playback_tick_ctrl.md
Name: playback_tick_ctrl

Overview:
Playback control stage that sits directly upstream of the elapsed-time counter (the seconds/minutes digit counter).
- Turns user/transport commands (play/pause, stop, fast-forward, end-of-track) into the signals that counter consumes: a 1 Hz tick, a count enable, a per-tick increment (adder) and a clear pulse.
- Runs entirely in the system clock domain.
- Divides the system clock down to a one-cycle-wide tick pulse.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock cycles per tick period (>= 2).
- FF_STEP, 4, seconds added per tick in fast-forward (1..9).
- ADDER_W, 6, width of the adder output.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-low reset.
- play_pause, in, 1, one-cycle command pulse that toggles between play and pause.
- stop, in, 1, one-cycle command pulse that stops playback and clears the time.
- end_of_track, in, 1, one-cycle pulse from the audio source; behaves as stop.
- ffwd, in, 1, level input: fast-forward is requested while it is high.
- tick, out, 1, one-cycle pulse once every CLK_FREQ_HZ cycles while running; drives the counter clock.
- count, out, 1, count enable to the counter.
- adder, out, ADDER_W, seconds to add per tick.
- timer_reset, out, 1, one-cycle clear pulse to the counter.
- state, out, 2, current FSM state (for display/debug).

Behaviour:
- Reset (reset=0, async): state=STOPPED, prescaler=0, tick=0, count=0, adder=0, timer_reset=0, init_pending=1.
- All outputs are registered; no combinational path from inputs to outputs.
- Startup clear: on the first clk edge after reset deasserts, timer_reset=1 for exactly one cycle and init_pending clears.
- States (2-bit):
  - STOPPED=0, PLAYING=1, PAUSED=2, FFWD=3.
- Command priority: stop > end_of_track > play_pause. ffwd is a level, evaluated every cycle.
- Transitions:
  - STOPPED: play_pause -> FFWD if ffwd=1, else PLAYING. end_of_track is ignored. stop stays in STOPPED but still pulses timer_reset.
  - PLAYING: stop or end_of_track -> STOPPED; else play_pause -> PAUSED; else ffwd=1 -> FFWD.
  - FFWD: stop or end_of_track -> STOPPED; else play_pause -> PAUSED; else ffwd=0 -> PLAYING.
  - PAUSED: stop or end_of_track -> STOPPED; play_pause -> FFWD if ffwd=1, else PLAYING. ffwd alone has no effect.
- timer_reset: one-cycle pulse on every edge where the next state is STOPPED because of stop or end_of_track (from any state), plus the startup pulse.
- Prescaler (width clog2(CLK_FREQ_HZ)), evaluated on the pre-edge state:
  - PLAYING/FFWD: increments each cycle. At CLK_FREQ_HZ-1 it wraps to 0 and tick=1 on that edge; tick=0 otherwise.
  - PAUSED: holds its value, so resume keeps the sub-second phase.
  - STOPPED, or any transition into STOPPED: cleared to 0.
- count/adder while no tick is being issued:
  - PLAYING: count=1, adder=1.
  - FFWD: count=1, adder=FF_STEP.
  - PAUSED/STOPPED: count=0, adder=0.
- Tick-edge stability:
  - On the edge that raises tick, count and adder take the values of the state that produced the tick (the pre-transition state), even if a command changes state on that same edge.
  - The new state's values appear on the next edge.
  - Guarantee: the downstream counter samples a consistent count/adder at tick's rising edge.
- Simultaneous events:
  - Tick wrap coinciding with stop: tick is still issued with the old count/adder, timer_reset is asserted in the same cycle, and the prescaler clears. Downstream, reset dominates.
  - play_pause and ffwd change in the same cycle: play_pause wins; the ffwd level is then applied on the next cycle.
- Reset mid-operation returns every output to its reset value immediately (async), with no tick glitch.

Decomposition:
- Shared package/header `playback_pkg`:
  - State encodings STOPPED/PLAYING/PAUSED/FFWD.
  - ADDER_W default.
- One sub-module, `tick_prescaler`:
  - Parameters: CLK_FREQ_HZ.
  - Inputs: clk, reset, run, hold, clear.
  - Output: wrap (registered).
  - The top level contains the FSM, the output registers and the timer_reset logic.

Test Plan (CLK_FREQ_HZ=10, FF_STEP=4):
1. Release reset -> timer_reset=1 for exactly 1 cycle; state=0; tick never asserts over 50 cycles.
2. play_pause pulse, ffwd=0 -> state=1; tick every 10 cycles, first tick 10 cycles after the command; count=1 and adder=1 at every tick.
3. Hold ffwd=1 while PLAYING -> state=3; adder=4 at the following ticks; tick spacing stays 10 cycles. Drop ffwd -> state=1, adder=1.
4. After 4 cycles of PLAYING, pause for 30 cycles, then resume -> no tick while paused; next tick 6 cycles after resume.
5. stop on the exact cycle the prescaler wraps -> tick=1 with count=1/adder=1, timer_reset=1 in the same cycle; state=0 next; prescaler=0.
6. Drive reset low mid-FFWD -> tick/count/adder/timer_reset=0 immediately; state=0. On release, exactly one startup timer_reset pulse.
